bcd_xs3_serializer: RTL

- Upstream neighbour of the serial XS3-to-BCD decoder.
- Accepts parallel BCD digits through a valid/ready handshake and buffers them in a small FIFO.
- Encodes each digit to excess-3 and drives a gapless serial stream on `y`, LSB first, one bit per clock.
- When no digit is available it sends an idle frame of 0000. 0000 is not a legal XS3 code, so the decoder holds its last output.

---
 rtl/bcd_xs3_pkg.sv | 29 ++
 rtl/bcd_digit_fifo.sv | 68 ++++++
 rtl/bcd_xs3_serializer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/bcd_xs3_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_xs3_pkg
//  Purpose  : Shared constants and the BCD to excess-3 encode helper for the
//             serial XS3 transmitter.
//  Config   : BCD_XS3_PARITY_EN - when defined, frames carry a fifth bit
//             (even parity over the four XS3 bits), so FRAME_LEN becomes 5.
//  Revision : 1.0 - initial release
// ============================================================================
package bcd_xs3_pkg;

    localparam logic [3:0] XS3_OFFSET = 4'd3;
    localparam logic [3:0] BCD_MAX    = 4'd9;
    // 0000 is not a legal XS3 code; the decoder holds its output on it.
    localparam logic [3:0] XS3_IDLE   = 4'b0000;

`ifdef BCD_XS3_PARITY_EN
    localparam int FRAME_LEN = 5;
`else
    localparam int FRAME_LEN = 4;
`endif

    // Only called for digits 0..9, so the sum never exceeds 4'd12.
    function automatic logic [3:0] xs3_encode(input logic [3:0] bcd);
        return bcd + XS3_OFFSET;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_digit_fifo
//  Purpose  : Synchronous FIFO of 4-bit codes. Push is ignored when full and
//             pop is ignored when empty. The head entry is presented
//             combinationally on o_pop_data.
//  Ports    : clk, rst (async, active-high)
//             i_push, i_push_data[3:0]  - write side
//             i_pop,  o_pop_data[3:0]   - read side (head of queue)
//             o_full, o_empty, o_level[LVL_W-1:0] - occupancy status
//  Revision : 1.0 - initial release
// ============================================================================
module bcd_digit_fifo #(
    parameter  int FIFO_DEPTH = 4,
    localparam int AW         = $clog2(FIFO_DEPTH),
    localparam int LVL_W      = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [3:0]       i_push_data,
    input  logic             i_pop,
    output logic [3:0]       o_pop_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [LVL_W-1:0] o_level
);

    logic [3:0]       r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LVL_W-1:0] r_level;

    logic w_push;
    logic w_pop;

    assign o_full     = (r_level == LVL_W'(FIFO_DEPTH));
    assign o_empty    = (r_level == '0);
    assign o_level    = r_level;
    assign o_pop_data = r_mem[r_rd_ptr];

    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop  & ~o_empty;

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_data;
    end

endmodule
`default_nettype wire

// File: rtl/bcd_xs3_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_xs3_serializer
//  Purpose  : Accepts BCD digits over valid/ready, buffers them, and sends
//             each as an excess-3 frame on y, LSB first, one bit per clock,
//             with no gaps between frames. An idle frame (all zeros) is sent
//             whenever no digit is waiting.
//  Config   : BCD_XS3_PARITY_EN - adds an even-parity bit as bit 4 of every
//             frame (frame length 5 instead of 4).
//  Ports    : clk, rst (async, active-high)
//             bcd_in[3:0], bcd_valid, bcd_ready - digit input handshake
//             y            - registered serial bit
//             frame_start  - high while y carries bit 0 of a frame
//             level        - FIFO occupancy
//             err_invalid  - sticky: a digit above 9 was offered
//             err_clr      - clears err_invalid (a same-cycle set wins)
//  Revision : 1.0 - initial release
// ============================================================================
module bcd_xs3_serializer #(
    parameter  int FIFO_DEPTH = 4,
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       bcd_in,
    input  logic             bcd_valid,
    output logic             bcd_ready,
    output logic             y,
    output logic             frame_start,
    output logic [LVL_W-1:0] level,
    output logic             err_invalid,
    input  logic             err_clr
);
    import bcd_xs3_pkg::*;

    localparam int                CNT_W      = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0]  c_cnt_last = CNT_W'(FRAME_LEN - 1);

    logic [CNT_W-1:0]     r_bit_cnt;
    logic [FRAME_LEN-1:0] r_sr;
    logic                 r_y;
    logic                 r_frame_start;
    logic                 r_err;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_accept;
    logic                 w_digit_ok;
    logic                 w_push;
    logic                 w_bad;
    logic                 w_wrap;
    logic                 w_pop;
    logic [3:0]           w_head;
    logic [FRAME_LEN-1:0] w_sr_next;

    // Ready depends only on the pre-edge level, so a push at full is refused
    // even when a pop happens on the same edge.
    assign bcd_ready  = ~w_full;
    assign w_accept   = bcd_valid & bcd_ready;
    assign w_digit_ok = (bcd_in <= BCD_MAX);
    // Out-of-range digits complete the handshake but are dropped.
    assign w_push     = w_accept & w_digit_ok;
    assign w_bad      = w_accept & ~w_digit_ok;

    assign w_wrap     = (r_bit_cnt == c_cnt_last);
    assign w_pop      = w_wrap & ~w_empty;

    bcd_digit_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (xs3_encode(bcd_in)),
        .i_pop       (w_pop),
        .o_pop_data  (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_level     (level)
    );

    // Next shift-register contents: shift right, or load a new frame on the
    // wrap edge. The FIFO emptiness seen here is pre-edge, so a digit written
    // on the wrap edge waits for the following frame.
    always_comb begin
        w_sr_next = {1'b0, r_sr[FRAME_LEN-1:1]};
        if (w_wrap) begin
`ifdef BCD_XS3_PARITY_EN
            w_sr_next = w_empty ? {1'b0, XS3_IDLE} : {^w_head, w_head};
`else
            w_sr_next = w_empty ? XS3_IDLE : w_head;
`endif
        end
    end

    // y lags the shift register LSB by one clock; frame_start is aligned to
    // y, so it is asserted on the edge leaving bit_cnt == 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_cnt     <= '0;
            r_sr          <= '0;
            r_y           <= 1'b0;
            r_frame_start <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_bit_cnt     <= w_wrap ? '0 : r_bit_cnt + CNT_W'(1);
            r_sr          <= w_sr_next;
            r_y           <= r_sr[0];
            r_frame_start <= (r_bit_cnt == '0);
            if (w_bad)        r_err <= 1'b1;
            else if (err_clr) r_err <= 1'b0;
        end
    end

    assign y           = r_y;
    assign frame_start = r_frame_start;
    assign err_invalid = r_err;

endmodule
`default_nettype wire
